// File: rtl/trig_angle_sequencer_pkg.sv
// Shared constants and FSM encoding for the trig angle sequencer and its
// modulo-360 reducer.
package trig_angle_sequencer_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] FUNC_SIN = 2'd0;
    localparam logic [1:0] FUNC_COS = 2'd1;
    localparam logic [1:0] FUNC_TAN = 2'd2;

    localparam logic [9:0] MOD_360 = 10'd360;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_FOLD   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/mod360_reducer.sv
// Bit-serial angle mod 360: consumes one angle bit per cycle, MSB first,
// keeping a running remainder that never reaches 360.
module mod360_reducer
    import trig_angle_sequencer_pkg::*;
#(
    parameter int ANGLE_W = DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ANGLE_W-1:0] angle,
    output logic               done,
    output logic [8:0]         rem
);

    localparam int CNT_W = $clog2(ANGLE_W + 1);

    logic [ANGLE_W-1:0] shift_q, shift_d;
    logic [8:0]         rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               active_q, active_d;
    logic [9:0]         trial;

    always_comb begin
        shift_d  = shift_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        trial    = {rem_q, shift_q[ANGLE_W-1]};
        done     = active_q && (cnt_q == CNT_W'(1));

        if (start) begin
            shift_d  = angle;
            rem_d    = '0;
            cnt_d    = CNT_W'(ANGLE_W);
            active_d = 1'b1;
        end else if (active_q) begin
            rem_d   = (trial >= MOD_360) ? 9'(trial - MOD_360) : trial[8:0];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (done) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q  <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/trig_angle_sequencer.sv
// Request controller in front of the shared 0..90 degree trig evaluator:
// reduces, folds, issues one evaluator job, then applies the quadrant sign.
module trig_angle_sequencer
    import trig_angle_sequencer_pkg::*;
#(
    parameter int ANGLE_W = DATA_WIDTH,
    parameter int RES_W   = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ANGLE_W-1:0] req_angle,
    input  logic [1:0]         req_func,
    output logic               eval_valid,
    input  logic               eval_ready,
    output logic [6:0]         eval_angle,
    output logic [1:0]         eval_func,
    input  logic               eval_rsp_valid,
    input  logic [RES_W-1:0]   eval_rsp_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [RES_W-1:0]   rsp_data,
    output logic [1:0]         rsp_quadrant,
    output logic               rsp_error,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [1:0]         func_q, func_d;
    logic [1:0]         quad_q, quad_d;
    logic [6:0]         ref_q, ref_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;
    logic [RES_W-1:0]   data_q, data_d;

    logic               red_start;
    logic               red_done;
    logic [8:0]         red_rem;

    logic [1:0]         fold_quad;
    logic [6:0]         fold_ref;
    logic               fold_neg;
    logic               fold_err;

    mod360_reducer #(
        .ANGLE_W (ANGLE_W)
    ) u_reducer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (red_start),
        .angle   (req_angle),
        .done    (red_done),
        .rem     (red_rem)
    );

    // Fold the reduced angle onto 0..90 and derive the sign the evaluator cannot see.
    always_comb begin
        fold_quad = 2'd0;
        fold_ref  = red_rem[6:0];
        if (red_rem < 9'd90) begin
            fold_quad = 2'd0;
            fold_ref  = red_rem[6:0];
        end else if (red_rem < 9'd180) begin
            fold_quad = 2'd1;
            fold_ref  = 7'(9'd180 - red_rem);
        end else if (red_rem < 9'd270) begin
            fold_quad = 2'd2;
            fold_ref  = 7'(red_rem - 9'd180);
        end else begin
            fold_quad = 2'd3;
            fold_ref  = 7'(9'd360 - red_rem);
        end

        case (func_q)
            FUNC_SIN: fold_neg = fold_quad[1];
            FUNC_COS: fold_neg = fold_quad[1] ^ fold_quad[0];
            FUNC_TAN: fold_neg = fold_quad[0];
            default:  fold_neg = 1'b0;
        endcase

        fold_err = (func_q == 2'd3) ||
                   ((func_q == FUNC_TAN) && ((red_rem == 9'd90) || (red_rem == 9'd270)));
    end

    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        quad_d    = quad_q;
        ref_d     = ref_q;
        neg_d     = neg_q;
        err_d     = err_q;
        data_d    = data_q;
        red_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    func_d    = req_func;
                    err_d     = 1'b0;
                    red_start = 1'b1;
                    state_d   = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (red_done) begin
                    state_d = ST_FOLD;
                end
            end
            ST_FOLD: begin
                quad_d = fold_quad;
                ref_d  = fold_ref;
                neg_d  = fold_neg;
                err_d  = fold_err;
                if (fold_err) begin
                    data_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (eval_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eval_rsp_valid) begin
                    data_d  = eval_rsp_data ^ {neg_q, {(RES_W-1){1'b0}}};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            func_q  <= '0;
            quad_q  <= '0;
            ref_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            func_q  <= func_d;
            quad_q  <= quad_d;
            ref_q   <= ref_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign eval_valid   = (state_q == ST_ISSUE);
    assign eval_angle   = ref_q;
    assign eval_func    = func_q;
    assign rsp_valid    = (state_q == ST_DONE);
    assign rsp_data     = data_q;
    assign rsp_quadrant = quad_q;
    assign rsp_error    = err_q;

endmodule
